fft_out_buf: RTL and testbench

//  Output stage directly downstream of the 64-point FFT core array. Collects the
//  64 complex results, delivered as 8 parallel samples per beat over 8 beats,

---
 rtl/fft_out_buf_if.sv | 31 +++
 rtl/fft_out_buf.sv | 115 +++++++++++
 tb/tb_fft_out_buf.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_out_buf_if.sv
// rtl/fft_out_buf_if.sv - beat-in / sample-out handshake bundle for fft_out_buf
interface fft_out_buf_if #(
  parameter int DATA_RE_WD = 16,
  parameter int DATA_IM_WD = 16,
  parameter int SIZE_FFT   = 64,
  parameter int PAR        = 8
);
  localparam int W  = DATA_RE_WD + DATA_IM_WD;
  localparam int AW = $clog2(SIZE_FFT);

  logic                         val_i;
  logic                         rdy_o;
  logic [PAR*W-1:0]             dat_i;
  logic                         val_o;
  logic                         rdy_i;
  logic signed [DATA_RE_WD-1:0] dat_re_o;
  logic signed [DATA_IM_WD-1:0] dat_im_o;
  logic [AW-1:0]                idx_o;
  logic                         sop_o;
  logic                         eop_o;

  modport master (
    output val_i, dat_i, rdy_i,
    input  rdy_o, val_o, dat_re_o, dat_im_o, idx_o, sop_o, eop_o
  );

  modport slave (
    input  val_i, dat_i, rdy_i,
    output rdy_o, val_o, dat_re_o, dat_im_o, idx_o, sop_o, eop_o
  );
endinterface

// File: rtl/fft_out_buf.sv
// rtl/fft_out_buf.sv - ping-pong buffer turning 8-lane FFT beats into a natural-order sample stream
// Build option FFT_OUT_BITREV_EN: input frames arrive bit-reversed; write address is bit-reversed.
module fft_out_buf #(
  parameter int DATA_RE_WD = 16,
  parameter int DATA_IM_WD = 16,
  parameter int SIZE_FFT   = 64,
  parameter int PAR        = 8
) (
  input logic          clk,
  input logic          rst,
  fft_out_buf_if.slave bus
);
  localparam int W  = DATA_RE_WD + DATA_IM_WD;
  localparam int AW = $clog2(SIZE_FFT);
  localparam int BW = $clog2(SIZE_FFT / PAR);
  localparam int LW = $clog2(PAR);

  logic [W-1:0]  mem_q [0:2*SIZE_FFT-1];
  logic [1:0]    full_q;
  logic          wr_bank_q;
  logic          rd_bank_q;
  logic [BW-1:0] beat_q;
  logic [AW-1:0] rd_cnt_q;
  logic          val_q;
  logic          sop_q;
  logic          eop_q;
  logic [AW-1:0] idx_q;
  logic [W-1:0]  dat_q;

  logic          wr_ok;
  logic          set_full;
  logic          xfer;
  logic          last_rd;
  logic          p_bank;
  logic [AW-1:0] p_cnt;
  logic          p_full;

  function automatic logic [AW-1:0] wr_addr(input logic [BW-1:0] b, input int l);
    logic [AW-1:0] a;
    a = {b, LW'(l)};
`ifdef FFT_OUT_BITREV_EN
    begin
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
      a = r;
    end
`endif
    return a;
  endfunction

  assign bus.rdy_o = rst && !full_q[wr_bank_q];
  assign wr_ok     = bus.val_i && bus.rdy_o;
  assign set_full  = wr_ok && (beat_q == BW'(SIZE_FFT / PAR - 1));
  assign xfer      = val_q && bus.rdy_i;
  assign last_rd   = xfer && (rd_cnt_q == '1);

  // Position the output register will present after this edge; lets the next
  // bank's k=0 follow an eop transfer without a bubble.
  assign p_bank = last_rd ? ~rd_bank_q : rd_bank_q;
  assign p_cnt  = xfer ? rd_cnt_q + 1'b1 : rd_cnt_q;
  assign p_full = full_q[p_bank];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int l = 0; l < PAR; l++) begin
        mem_q[{wr_bank_q, wr_addr(beat_q, l)}] <= bus.dat_i[l*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      beat_q    <= '0;
      rd_cnt_q  <= '0;
      val_q     <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      idx_q     <= '0;
      dat_q     <= '0;
    end else begin
      if (wr_ok) begin
        beat_q <= beat_q + 1'b1;
        if (set_full) begin
          full_q[wr_bank_q] <= 1'b1;
          wr_bank_q         <= ~wr_bank_q;
        end
      end
      // Set and clear always target different banks, so both bit writes stand.
      if (xfer) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
        if (last_rd) begin
          full_q[rd_bank_q] <= 1'b0;
          rd_bank_q         <= ~rd_bank_q;
        end
      end
      if (!val_q || xfer) begin
        val_q <= p_full;
        idx_q <= p_cnt;
        sop_q <= p_full && (p_cnt == '0);
        eop_q <= p_full && (p_cnt == '1);
        if (p_full) dat_q <= mem_q[{p_bank, p_cnt}];
      end
    end
  end

  assign bus.val_o    = val_q;
  assign bus.idx_o    = idx_q;
  assign bus.sop_o    = sop_q;
  assign bus.eop_o    = eop_q;
  assign bus.dat_re_o = dat_q[W-1 -: DATA_RE_WD];
  assign bus.dat_im_o = dat_q[DATA_IM_WD-1:0];
endmodule

// File: tb/tb_fft_out_buf.sv
// tb/tb_fft_out_buf.sv - scoreboard bench for fft_out_buf (single, back-to-back, random stall, reset, bit-reverse)
module tb_fft_out_buf;
  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [5:0]  idx;
    logic        sop;
    logic        eop;
  } smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_out_buf_if bus ();
  fft_out_buf dut (.clk(clk), .rst(rst), .bus(bus.slave));

  smp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_to = 0;
  int   test_id = 0;
  bit   rnd_mode = 1'b0;
  bit   done = 1'b0;

  function automatic logic [5:0] bitrev6(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = a[5-i];
    return r;
  endfunction

  // Input word at position p carries this value in its real part, its negation in imag.
  function automatic logic [15:0] val_of(input int tag, input int mode, input int p);
    logic [5:0] p6;
    p6 = 6'(p);
    return 16'(tag * 256) + 16'(mode != 0 ? bitrev6(p6) : p6);
  endfunction

  task automatic send_frame(input int tag, input int mode, input int nbeats, input bit push);
    logic [255:0] d;
    logic [15:0]  v;
    int           n;
    for (int b = 0; b < nbeats; b++) begin
      for (int l = 0; l < 8; l++) begin
        v = val_of(tag, mode, b * 8 + l);
        d[l*32 +: 32] = {v, 16'(-v)};
      end
      bus.val_i = 1'b1;
      bus.dat_i = d;
      n = 0;
      forever begin
        @(negedge clk);
        if (bus.rdy_o) break;
        n++;
        if (n > 2000) begin
          n_to++;
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.val_i = 1'b0;
    if (push) begin
      for (int k = 0; k < 64; k++) begin
        smp_t e;
        int   p;
`ifdef FFT_OUT_BITREV_EN
        p = int'(bitrev6(6'(k)));
`else
        p = k;
`endif
        v     = val_of(tag, mode, p);
        e.re  = v;
        e.im  = 16'(-v);
        e.idx = 6'(k);
        e.sop = (k == 0);
        e.eop = (k == 63);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) n_to++;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rdy_i = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    bus.val_i = 1'b0;
    bus.dat_i = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    send_frame(0, 0, 8, 1'b1);
    wait_drain();
    test_id = 2;
    send_frame(1, 0, 8, 1'b1);
    send_frame(2, 0, 8, 1'b1);
    send_frame(3, 0, 8, 1'b1);
    wait_drain();
    test_id = 3;
    rnd_mode = 1'b1;
    send_frame(4, 0, 8, 1'b1);
    send_frame(5, 0, 8, 1'b1);
    send_frame(6, 0, 8, 1'b1);
    wait_drain();
    rnd_mode = 1'b0;
    test_id = 4;
    send_frame(7, 0, 5, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    send_frame(8, 0, 8, 1'b1);
    wait_drain();
    test_id = 5;
    send_frame(0, 1, 8, 1'b1);
    wait_drain();
    done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before 50000 cycles");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int          cyc = 0;
  int          occ = 0;
  int          beat_m = 0;
  int          lat_st = 0;
  int          t2_first = -1;
  int          t2_last = -1;
  bit          prev_stall = 1'b0;
  logic [40:0] held = '0;
  logic [40:0] cur;
  smp_t        got;
  smp_t        e;
  bit          xfer;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("rst_val_o", 64'(bus.val_o), 64'd0);
      chk("rst_idx_sop_eop", 64'({bus.idx_o, bus.sop_o, bus.eop_o}), 64'd0);
      chk("rst_dat", 64'({bus.dat_re_o, bus.dat_im_o}), 64'd0);
      beat_m = 0;
      occ = 0;
      lat_st = 0;
      prev_stall = 1'b0;
    end else begin
      xfer = bus.val_o && bus.rdy_i;
      if (lat_st == 1) begin
        chk("latency_cycle1_val_o", 64'(bus.val_o), 64'd0);
        lat_st = 2;
      end else if (lat_st == 2) begin
        chk("latency_cycle2_val_o", 64'(bus.val_o), 64'd1);
        lat_st = 0;
      end
      cur = {bus.val_o, bus.dat_re_o, bus.dat_im_o, bus.idx_o, bus.sop_o, bus.eop_o};
      if (prev_stall) chk("stall_hold", 64'(cur), 64'(held));
      prev_stall = bus.val_o && !bus.rdy_i;
      held = cur;
      chk("rdy_o_vs_full", 64'(bus.rdy_o), 64'(occ < 2));
      if (xfer) begin
        got = {bus.dat_re_o, bus.dat_im_o, bus.idx_o, bus.sop_o, bus.eop_o};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_unexpected: got idx %0d re %0h, required no output", got.idx, got.re);
        end else begin
          e = exp_q.pop_front();
          chk("out_sample", 64'(got), 64'(e));
        end
        if (test_id == 2) begin
          if (t2_first < 0) t2_first = cyc;
          t2_last = cyc;
        end
      end
      if (bus.val_i && bus.rdy_o) begin
        if (beat_m == 7) begin
          if (occ == 0 && !bus.val_o) lat_st = 1;
          occ++;
          beat_m = 0;
        end else begin
          beat_m++;
        end
      end
      if (xfer && bus.eop_o) occ--;
      if (done) begin
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("b2b_span", 64'(t2_last - t2_first), 64'd191);
        chk("timeouts", 64'(n_to), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end
endmodule
